// File: rtl/pipe_control_pkg.sv
// rtl/pipe_control_pkg.sv - opcodes, ALU/forward encodings and control bundle for the MIPS pipeline control
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic       regdst;
    logic       jump;
    logic       branch_eq;
    logic       branch_ne;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] aluop;
  } ctrl_t;

  // Instructions whose rt field is a source operand rather than a destination
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/pipe_control_if.sv
// rtl/pipe_control_if.sv - ID-stage inputs and pipeline control outputs of pipe_control
interface pipe_control_if #(parameter int REG_AW = 5);
  logic [5:0]        id_opcode;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_br_equal;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              id_jump;
  logic              id_branch_taken;
  logic              ex_alusrc;
  logic [1:0]        ex_aluop;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_wreg;
  logic              mem_read;
  logic              mem_write;
  logic [REG_AW-1:0] mem_wreg;
  logic              wb_regwrite;
  logic              wb_memtoreg;
  logic [REG_AW-1:0] wb_wreg;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              illegal_op;

  modport master (
    output id_opcode, id_rs, id_rt, id_rd, id_br_equal,
    input  pc_write, ifid_write, ifid_flush, id_jump, id_branch_taken,
    input  ex_alusrc, ex_aluop, ex_rs, ex_rt, ex_wreg,
    input  mem_read, mem_write, mem_wreg,
    input  wb_regwrite, wb_memtoreg, wb_wreg,
    input  fwd_a, fwd_b, illegal_op
  );

  modport slave (
    input  id_opcode, id_rs, id_rt, id_rd, id_br_equal,
    output pc_write, ifid_write, ifid_flush, id_jump, id_branch_taken,
    output ex_alusrc, ex_aluop, ex_rs, ex_rt, ex_wreg,
    output mem_read, mem_write, mem_wreg,
    output wb_regwrite, wb_memtoreg, wb_wreg,
    output fwd_a, fwd_b, illegal_op
  );
endinterface

// File: rtl/pipe_control_decode.sv
// rtl/pipe_control_decode.sv - combinational opcode to control bundle table
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl,
  output logic       illegal_op
);

  // Unknown opcodes decode to an all-zero bundle so they flow as a bubble
  always_comb begin
    ctrl       = '0;
    illegal_op = 1'b0;
    case (opcode)
      OP_RTYPE: begin ctrl.regdst = 1'b1; ctrl.regwrite = 1'b1; ctrl.aluop = ALUOP_FUNCT; end
      OP_J:     begin ctrl.jump = 1'b1; end
      OP_BEQ:   begin ctrl.branch_eq = 1'b1; ctrl.aluop = ALUOP_SUB; end
      OP_BNE:   begin ctrl.branch_ne = 1'b1; ctrl.aluop = ALUOP_SUB; end
      OP_ADDI:  begin ctrl.alusrc = 1'b1; ctrl.regwrite = 1'b1; ctrl.aluop = ALUOP_ADD; end
      OP_ANDI:  begin ctrl.alusrc = 1'b1; ctrl.regwrite = 1'b1; ctrl.aluop = ALUOP_AND; end
      OP_LW: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
      end
      OP_SW:    begin ctrl.alusrc = 1'b1; ctrl.memwrite = 1'b1; ctrl.aluop = ALUOP_ADD; end
      default:  illegal_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_control.sv
// rtl/pipe_control.sv - pipelined control: decode, ID/EX/MEM/WB control registers, hazards, forwarding
module pipe_control
  import mips_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  pipe_control_if.slave bus
);

  ctrl_t             id_ctrl;
  logic              id_illegal;
  logic [REG_AW-1:0] id_wreg;
  logic              id_uses_rt;
  logic              id_is_branch;

  logic              ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_alusrc;
  logic [1:0]        ex_aluop;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_wreg;
  logic              mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite;
  logic [REG_AW-1:0] mem_wreg;
  logic              wb_regwrite, wb_memtoreg;
  logic [REG_AW-1:0] wb_wreg;

  logic              ex_wr, ex_ld, mem_wr, mem_ld, wb_wr;
  logic              hit_ex_src, hit_ex_any, hit_mem_src, hit_mem_any;
  logic              stall;
  logic [1:0]        fwd_a, fwd_b;

  ctrl_decode u_decode (
    .opcode     (bus.id_opcode),
    .ctrl       (id_ctrl),
    .illegal_op (id_illegal)
  );

  assign id_wreg      = id_ctrl.regdst ? bus.id_rd : bus.id_rt;
  assign id_uses_rt   = uses_rt(bus.id_opcode);
  assign id_is_branch = id_ctrl.branch_eq | id_ctrl.branch_ne;

  // Register 0 is hardwired, so a write to it never counts as a producer
  assign ex_wr  = ex_regwrite  & (ex_wreg  != '0);
  assign ex_ld  = ex_memread   & (ex_wreg  != '0);
  assign mem_wr = mem_regwrite & (mem_wreg != '0);
  assign mem_ld = mem_memread  & (mem_wreg != '0);
  assign wb_wr  = wb_regwrite  & (wb_wreg  != '0);

  // Load-use, branch-operand and (without forwarding) general RAW hazard detection
  always_comb begin
    hit_ex_src  = (ex_wreg == bus.id_rs) | (id_uses_rt & (ex_wreg == bus.id_rt));
    hit_ex_any  = (ex_wreg == bus.id_rs) | (ex_wreg == bus.id_rt);
    hit_mem_src = (mem_wreg == bus.id_rs) | (id_uses_rt & (mem_wreg == bus.id_rt));
    hit_mem_any = (mem_wreg == bus.id_rs) | (mem_wreg == bus.id_rt);
    stall = (ex_ld & hit_ex_src)
          | (id_is_branch & ex_wr & hit_ex_any)
          | (id_is_branch & mem_ld & hit_mem_any)
          | (!FWD_EN & ((ex_wr & hit_ex_src) | (mem_wr & hit_mem_src)));
  end

  // ID/EX register: a stall injects a bubble by zeroing the control bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_regwrite <= 1'b0; ex_memtoreg <= 1'b0; ex_memread <= 1'b0;
      ex_memwrite <= 1'b0; ex_alusrc   <= 1'b0; ex_aluop   <= 2'b00;
      ex_rs <= '0; ex_rt <= '0; ex_wreg <= '0;
    end else begin
      ex_regwrite <= id_ctrl.regwrite & !stall;
      ex_memtoreg <= id_ctrl.memtoreg & !stall;
      ex_memread  <= id_ctrl.memread  & !stall;
      ex_memwrite <= id_ctrl.memwrite & !stall;
      ex_alusrc   <= id_ctrl.alusrc   & !stall;
      ex_aluop    <= stall ? 2'b00 : id_ctrl.aluop;
      ex_rs       <= bus.id_rs;
      ex_rt       <= bus.id_rt;
      ex_wreg     <= id_wreg;
    end
  end

  // EX/MEM and MEM/WB registers always advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_regwrite <= 1'b0; mem_memtoreg <= 1'b0; mem_memread <= 1'b0;
      mem_memwrite <= 1'b0; mem_wreg <= '0;
      wb_regwrite  <= 1'b0; wb_memtoreg  <= 1'b0; wb_wreg <= '0;
    end else begin
      mem_regwrite <= ex_regwrite;
      mem_memtoreg <= ex_memtoreg;
      mem_memread  <= ex_memread;
      mem_memwrite <= ex_memwrite;
      mem_wreg     <= ex_wreg;
      wb_regwrite  <= mem_regwrite;
      wb_memtoreg  <= mem_memtoreg;
      wb_wreg      <= mem_wreg;
    end
  end

  // Forwarding selects for the EX operands; the younger MEM result wins over WB
  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (FWD_EN) begin
      if (mem_wr && (mem_wreg == ex_rs))     fwd_a = FWD_MEM;
      else if (wb_wr && (wb_wreg == ex_rs))  fwd_a = FWD_WB;
      if (mem_wr && (mem_wreg == ex_rt))     fwd_b = FWD_MEM;
      else if (wb_wr && (wb_wreg == ex_rt))  fwd_b = FWD_WB;
    end
  end

  assign bus.pc_write        = !stall;
  assign bus.ifid_write      = !stall;
  assign bus.id_jump         = !stall & id_ctrl.jump;
  assign bus.id_branch_taken = !stall & ((id_ctrl.branch_eq & bus.id_br_equal) |
                                         (id_ctrl.branch_ne & !bus.id_br_equal));
  assign bus.ifid_flush      = bus.id_branch_taken | bus.id_jump;
  assign bus.illegal_op      = id_illegal;
  assign bus.ex_alusrc       = ex_alusrc;
  assign bus.ex_aluop        = ex_aluop;
  assign bus.ex_rs           = ex_rs;
  assign bus.ex_rt           = ex_rt;
  assign bus.ex_wreg         = ex_wreg;
  assign bus.mem_read        = mem_memread;
  assign bus.mem_write       = mem_memwrite;
  assign bus.mem_wreg        = mem_wreg;
  assign bus.wb_regwrite     = wb_regwrite;
  assign bus.wb_memtoreg     = wb_memtoreg;
  assign bus.wb_wreg         = wb_wreg;
  assign bus.fwd_a           = fwd_a;
  assign bus.fwd_b           = fwd_b;

endmodule

// File: tb/tb_pipe_control.sv
// tb/tb_pipe_control.sv - directed self-checking bench for pipe_control
module tb_pipe_control;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode;
  logic [4:0] rs, rt, rd;
  logic       br_equal;
  int         checks = 0;
  int         errors = 0;

  pipe_control_if #(.REG_AW(5)) bus1 ();
  pipe_control_if #(.REG_AW(5)) bus0 ();

  assign bus1.id_opcode = opcode;  assign bus0.id_opcode = opcode;
  assign bus1.id_rs = rs;          assign bus0.id_rs = rs;
  assign bus1.id_rt = rt;          assign bus0.id_rt = rt;
  assign bus1.id_rd = rd;          assign bus0.id_rd = rd;
  assign bus1.id_br_equal = br_equal;
  assign bus0.id_br_equal = br_equal;

  pipe_control #(.REG_AW(5), .FWD_EN(1'b1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  pipe_control #(.REG_AW(5), .FWD_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic eq);
    opcode = op; rs = s; rt = t; rd = d; br_equal = eq;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_id(OP_RTYPE, 0, 0, 0, 1'b0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_id(OP_LW, 1, 2, 0, 1'b0);
    @(posedge clk);
    #2;
    checks++; if (bus1.ex_alusrc !== 1'b0) begin errors++; $display("FAIL rst_ex_alusrc got %0b exp 0", bus1.ex_alusrc); end
    checks++; if (bus1.mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read got %0b exp 0", bus1.mem_read); end
    checks++; if (bus1.wb_regwrite !== 1'b0) begin errors++; $display("FAIL rst_wb_regwrite got %0b exp 0", bus1.wb_regwrite); end
    checks++; if (bus1.ex_wreg !== 5'd0) begin errors++; $display("FAIL rst_ex_wreg got %0d exp 0", bus1.ex_wreg); end
    checks++; if (bus1.pc_write !== 1'b1) begin errors++; $display("FAIL rst_pc_write got %0b exp 1", bus1.pc_write); end
    checks++; if (bus1.ifid_flush !== 1'b0) begin errors++; $display("FAIL rst_ifid_flush got %0b exp 0", bus1.ifid_flush); end
    checks++; if (bus1.fwd_a !== 2'b00) begin errors++; $display("FAIL rst_fwd_a got %0b exp 00", bus1.fwd_a); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(OP_LW, 1, 2, 0, 1'b0); #2;
    checks++; if (bus1.pc_write !== 1'b1) begin errors++; $display("FAIL lu_pc_first got %0b exp 1", bus1.pc_write); end
    tick();
    set_id(OP_RTYPE, 2, 4, 3, 1'b0); #2;
    checks++; if (bus1.pc_write !== 1'b0) begin errors++; $display("FAIL lu_pc_stall got %0b exp 0", bus1.pc_write); end
    checks++; if (bus1.ifid_write !== 1'b0) begin errors++; $display("FAIL lu_ifid_stall got %0b exp 0", bus1.ifid_write); end
    tick();
    #2;
    checks++; if (bus1.ex_alusrc !== 1'b0) begin errors++; $display("FAIL lu_ex_bubble got %0b exp 0", bus1.ex_alusrc); end
    checks++; if (bus1.mem_read !== 1'b1) begin errors++; $display("FAIL lu_mem_read got %0b exp 1", bus1.mem_read); end
    checks++; if (bus1.pc_write !== 1'b1) begin errors++; $display("FAIL lu_pc_resume got %0b exp 1", bus1.pc_write); end
    tick();
    set_id(OP_RTYPE, 0, 0, 0, 1'b0); #2;
    checks++; if (bus1.fwd_a !== FWD_WB) begin errors++; $display("FAIL lu_fwd_a got %0b exp 01", bus1.fwd_a); end
    checks++; if (bus1.ex_aluop !== ALUOP_FUNCT) begin errors++; $display("FAIL lu_ex_aluop got %0b exp 10", bus1.ex_aluop); end
    checks++; if (bus1.wb_memtoreg !== 1'b1) begin errors++; $display("FAIL lu_wb_memtoreg got %0b exp 1", bus1.wb_memtoreg); end
    tick();
  endtask

  task automatic test_ex_forward();
    do_reset();
    set_id(OP_RTYPE, 1, 1, 2, 1'b0); #2; tick();
    set_id(OP_RTYPE, 2, 2, 3, 1'b0); #2;
    checks++; if (bus1.pc_write !== 1'b1) begin errors++; $display("FAIL exf_no_stall got %0b exp 1", bus1.pc_write); end
    tick();
    set_id(OP_RTYPE, 0, 0, 0, 1'b0); #2;
    checks++; if (bus1.fwd_a !== FWD_MEM) begin errors++; $display("FAIL exf_fwd_a got %0b exp 10", bus1.fwd_a); end
    checks++; if (bus1.fwd_b !== FWD_MEM) begin errors++; $display("FAIL exf_fwd_b got %0b exp 10", bus1.fwd_b); end
    checks++; if (bus1.ex_wreg !== 5'd3) begin errors++; $display("FAIL exf_ex_wreg got %0d exp 3", bus1.ex_wreg); end
    tick();
  endtask

  task automatic test_branch_after_load();
    do_reset();
    set_id(OP_LW, 1, 5, 0, 1'b0); #2; tick();
    set_id(OP_BEQ, 5, 0, 0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      #2;
      checks++; if (bus1.pc_write !== 1'b0) begin errors++; $display("FAIL brl_stall%0d got %0b exp 0", c, bus1.pc_write); end
      checks++; if (bus1.ifid_flush !== 1'b0) begin errors++; $display("FAIL brl_noflush%0d got %0b exp 0", c, bus1.ifid_flush); end
      tick();
    end
    #2;
    checks++; if (bus1.id_branch_taken !== 1'b1) begin errors++; $display("FAIL brl_taken got %0b exp 1", bus1.id_branch_taken); end
    checks++; if (bus1.ifid_flush !== 1'b1) begin errors++; $display("FAIL brl_flush got %0b exp 1", bus1.ifid_flush); end
    checks++; if (bus1.pc_write !== 1'b1) begin errors++; $display("FAIL brl_pc got %0b exp 1", bus1.pc_write); end
    tick();
    set_id(OP_RTYPE, 0, 0, 0, 1'b0); #2;
    checks++; if (bus1.ifid_flush !== 1'b0) begin errors++; $display("FAIL brl_flush_once got %0b exp 0", bus1.ifid_flush); end
    tick();
  endtask

  task automatic test_bne_jump();
    do_reset();
    set_id(OP_BEQ, 1, 2, 0, 1'b0); #2;
    checks++; if (bus1.ifid_flush !== 1'b0) begin errors++; $display("FAIL beq_nt_flush got %0b exp 0", bus1.ifid_flush); end
    tick();
    set_id(OP_BNE, 1, 2, 0, 1'b0); #2;
    checks++; if (bus1.id_branch_taken !== 1'b1) begin errors++; $display("FAIL bne_taken got %0b exp 1", bus1.id_branch_taken); end
    checks++; if (bus1.ifid_flush !== 1'b1) begin errors++; $display("FAIL bne_flush got %0b exp 1", bus1.ifid_flush); end
    tick();
    set_id(OP_J, 0, 0, 0, 1'b0); #2;
    checks++; if (bus1.id_jump !== 1'b1) begin errors++; $display("FAIL j_jump got %0b exp 1", bus1.id_jump); end
    checks++; if (bus1.ifid_flush !== 1'b1) begin errors++; $display("FAIL j_flush got %0b exp 1", bus1.ifid_flush); end
    checks++; if (bus1.id_branch_taken !== 1'b0) begin errors++; $display("FAIL j_taken got %0b exp 0", bus1.id_branch_taken); end
    tick();
    set_id(OP_RTYPE, 0, 0, 0, 1'b0);
    tick(); tick(); #2;
    checks++; if (bus1.wb_regwrite !== 1'b0) begin errors++; $display("FAIL j_wb_regwrite got %0b exp 0", bus1.wb_regwrite); end
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    set_id(6'b111111, 1, 2, 3, 1'b0); #2;
    checks++; if (bus1.illegal_op !== 1'b1) begin errors++; $display("FAIL ill_flag got %0b exp 1", bus1.illegal_op); end
    tick();
    set_id(OP_RTYPE, 0, 0, 0, 1'b0); #2;
    checks++; if (bus1.illegal_op !== 1'b0) begin errors++; $display("FAIL ill_clear got %0b exp 0", bus1.illegal_op); end
    checks++; if (bus1.ex_alusrc !== 1'b0) begin errors++; $display("FAIL ill_ex_alusrc got %0b exp 0", bus1.ex_alusrc); end
    tick(); #2;
    checks++; if (bus1.mem_read !== 1'b0 || bus1.mem_write !== 1'b0) begin errors++; $display("FAIL ill_mem got %0b%0b exp 00", bus1.mem_read, bus1.mem_write); end
    tick(); #2;
    checks++; if (bus1.wb_regwrite !== 1'b0) begin errors++; $display("FAIL ill_wb_regwrite got %0b exp 0", bus1.wb_regwrite); end
    tick();
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_id(OP_RTYPE, 1, 1, 0, 1'b0); #2; tick();
    set_id(OP_RTYPE, 0, 0, 4, 1'b0); #2;
    checks++; if (bus1.pc_write !== 1'b1) begin errors++; $display("FAIL zr_no_stall got %0b exp 1", bus1.pc_write); end
    tick();
    set_id(OP_LW, 1, 0, 0, 1'b0); #2;
    checks++; if (bus1.fwd_a !== 2'b00 || bus1.fwd_b !== 2'b00) begin errors++; $display("FAIL zr_no_fwd got %0b/%0b exp 00/00", bus1.fwd_a, bus1.fwd_b); end
    tick();
    set_id(OP_RTYPE, 0, 0, 6, 1'b0); #2;
    checks++; if (bus1.pc_write !== 1'b1) begin errors++; $display("FAIL zr_load_no_stall got %0b exp 1", bus1.pc_write); end
    tick();
  endtask

  task automatic test_no_fwd();
    do_reset();
    set_id(OP_RTYPE, 1, 1, 2, 1'b0); #2; tick();
    set_id(OP_RTYPE, 2, 2, 3, 1'b0);
    for (int c = 0; c < 2; c++) begin
      #2;
      checks++; if (bus0.pc_write !== 1'b0 || bus0.ifid_write !== 1'b0) begin errors++; $display("FAIL nf_stall%0d got %0b%0b exp 00", c, bus0.pc_write, bus0.ifid_write); end
      checks++; if (bus0.fwd_a !== 2'b00 || bus0.fwd_b !== 2'b00) begin errors++; $display("FAIL nf_fwd%0d got %0b/%0b exp 00/00", c, bus0.fwd_a, bus0.fwd_b); end
      tick();
    end
    #2;
    checks++; if (bus0.pc_write !== 1'b1) begin errors++; $display("FAIL nf_resume got %0b exp 1", bus0.pc_write); end
    tick();
    set_id(OP_RTYPE, 3, 3, 6, 1'b0); #2;
    checks++; if (bus0.pc_write !== 1'b0) begin errors++; $display("FAIL nf_stall_pre_rst got %0b exp 0", bus0.pc_write); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus0.pc_write !== 1'b1) begin errors++; $display("FAIL nf_rst_pc got %0b exp 1", bus0.pc_write); end
    checks++; if (bus0.ex_wreg !== 5'd0 || bus0.ex_aluop !== 2'b00) begin errors++; $display("FAIL nf_rst_ex got %0d/%0b exp 0/00", bus0.ex_wreg, bus0.ex_aluop); end
    checks++; if (bus0.mem_wreg !== 5'd0 || bus0.wb_wreg !== 5'd0) begin errors++; $display("FAIL nf_rst_wreg got %0d/%0d exp 0/0", bus0.mem_wreg, bus0.wb_wreg); end
    checks++; if (bus0.wb_regwrite !== 1'b0) begin errors++; $display("FAIL nf_rst_wb got %0b exp 0", bus0.wb_regwrite); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    set_id(OP_RTYPE, 0, 0, 0, 1'b0);
    test_reset();
    test_load_use();
    test_ex_forward();
    test_branch_after_load();
    test_bne_jump();
    test_illegal();
    test_zero_reg();
    test_no_fwd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_control.md
Name: pipe_control

Overview:
- Pipelined successor to the single-cycle main decoder for the 5-stage MIPS core.
- Decodes the ID-stage opcode and carries the control bundle through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use and branch-operand hazards and generates stall, flush and forwarding selects.
- Branches and jumps resolve in ID. The register file is write-first, so WB-to-ID needs no hazard handling.

Parameters:
REG_AW, 5, register address width
FWD_EN, 1, 1: EX forwarding muxes present; 0: no forwarding, hazard unit stalls on every RAW against EX/MEM

Ports:
clk  in  1  core clock
rst_n  in  1  reset
id_opcode  in  6  instruction[31:26] in ID
id_rs  in  REG_AW  source register 1 in ID
id_rt  in  REG_AW  source register 2 in ID
id_rd  in  REG_AW  R-type destination in ID
id_br_equal  in  1  ID comparator result (rs==rt, post-forward)
pc_write  out  1  PC enable
ifid_write  out  1  IF/ID enable
ifid_flush  out  1  zero IF/ID on next edge
id_jump  out  1  select jump target
id_branch_taken  out  1  select branch target
ex_alusrc  out  1  ALU B = immediate
ex_aluop  out  2  00 add, 01 sub, 10 funct, 11 and
ex_rs  out  REG_AW  registered rs
ex_rt  out  REG_AW  registered rt
ex_wreg  out  REG_AW  EX destination (already regdst-muxed)
mem_read  out  1  memory read
mem_write  out  1  memory write
mem_wreg  out  REG_AW  MEM destination
wb_regwrite  out  1  register file write enable
wb_memtoreg  out  1  WB selects memory data
wb_wreg  out  REG_AW  WB destination
fwd_a  out  2  ALU A select: 00 regfile, 01 WB, 10 MEM
fwd_b  out  2  ALU B select, same encoding
illegal_op  out  1  ID opcode not in decode table

Behaviour:
- Reset:
  - Asynchronous, active-low; one clock, rst_n (clock port clk).
  - While rst_n=0, all ID/EX, EX/MEM and MEM/WB control registers are 0 and all address registers are 0, so every stage holds a bubble.
  - Out of reset: pc_write=1, ifid_write=1, ifid_flush=0, fwd_a=fwd_b=00.
  - Reset asserted mid-stall or mid-flush clears everything immediately; no pending state survives.
- Decode (combinational on id_opcode):
  - 000000 R-type: regdst=1, regwrite=1, aluop=10.
  - 000010 j: jump=1 only; regwrite=0.
  - 000100 beq: branch_eq, aluop=01, regwrite=0.
  - 000101 bne: branch_ne, aluop=01, regwrite=0.
  - 001000 addi: alusrc=1, regwrite=1, aluop=00.
  - 001100 andi: alusrc=1, regwrite=1, aluop=11.
  - 100011 lw: alusrc=1, memread=1, memtoreg=1, regwrite=1, aluop=00.
  - 101011 sw: alusrc=1, memwrite=1, aluop=00.
  - Any other opcode: all controls 0 (NOP) and illegal_op=1.
- Destination register and reads:
  - wreg = regdst ? id_rd : id_rt.
  - A write to register 0 never counts as a writer (treated as regwrite=0 for hazards and forwarding).
  - uses_rt: R-type, beq, bne, sw.
- Hazard, stall:
  - stall=1 if any of the following holds:
    - (a) EX holds a load whose wreg matches rs, or matches rt with uses_rt.
    - (b) ID holds beq/bne and EX regwrite targets rs/rt.
    - (c) ID holds beq/bne and MEM holds a load targeting rs/rt.
    - (d) FWD_EN=0 only: EX or MEM regwrite targets rs, or rt with uses_rt.
  - stall → pc_write=0, ifid_write=0, and ID/EX control registers load 0 (bubble) on the next edge. EX/MEM and MEM/WB advance normally.
  - A lw followed by a dependent beq stalls 2 cycles via (a) then (c); the repeat stall is not counted.
- Flush:
  - id_branch_taken = !stall & ((branch_eq & id_br_equal) | (branch_ne & !id_br_equal)).
  - id_jump = !stall & jump.
  - ifid_flush = id_branch_taken | id_jump.
  - Stall has priority: while stalled, the branch outcome is ignored and no flush occurs.
- Forwarding (combinational from registered state; FWD_EN=0 forces 00):
  - fwd_a=10 if MEM regwrite & mem_wreg!=0 & mem_wreg==ex_rs.
  - else fwd_a=01 if WB regwrite & wb_wreg!=0 & wb_wreg==ex_rs.
  - else fwd_a=00.
  - fwd_b is identical with ex_rt. MEM wins over WB.
- Latency: ID controls appear on ex_* one edge later, mem_* two edges later, wb_* three edges later.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants;
  - ALUOP_ADD/SUB/FUNCT/AND;
  - FWD_REG/FWD_WB/FWD_MEM;
  - ctrl_t packed struct {regdst, jump, branch_eq, branch_ne, memread, memtoreg, memwrite, alusrc, regwrite, aluop}.
- Sub-module ctrl_decode: the combinational opcode → ctrl_t table plus illegal_op.
- pipe_control instantiates ctrl_decode and contains the pipeline registers, the hazard logic and the forwarding logic.

Test Plan:
- lw $2,0($1); add $3,$2,$4 → one cycle with pc_write=0, ifid_write=0 and EX bubble; then fwd_a=01 for the add in EX.
- add $2,$1,$1; sub $3,$2,$2 → no stall; fwd_a=fwd_b=10 when sub is in EX.
- lw $5,..; beq $5,$0,L with id_br_equal=1 → 2 stall cycles with no flush; then id_branch_taken=1, ifid_flush=1 for exactly 1 cycle.
- bne with id_br_equal=0 → taken and flushed. j with no hazards → id_jump=1, ifid_flush=1, and wb_regwrite stays 0 three cycles later.
- Opcode 111111 → illegal_op=1 and all downstream controls 0. add $0,... followed by a reader of $0 → no forward, no stall.
- FWD_EN=0: add $2; add $3,$2 → 2 stall cycles and fwd_*=00 throughout. Assert rst_n low mid-stall → all registers 0 and pc_write=1 immediately.
